l2_port_arbiter: RTL and testbench

//  Shares the single L2 line port between the L1 I-cache (line reads) and the L1 D-cache
//  (line reads and dirty-line writebacks of merged 128-bit lines).

---
 rtl/l2_port_arbiter_pkg.sv | 14 +
 rtl/l2_arb_pick.sv | 30 +++
 rtl/l2_port_arbiter.sv | 132 +++++++++++++
 tb/tb_l2_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_port_arbiter_pkg.sv
// Shared L2 arbiter types: lc3b line/word widths, FSM states and grant side.
// Optional round-robin arbitration is selected with L2ARB_RR_EN (see l2_arb_pick).
package l2_port_arbiter_pkg;

  localparam int LC3B_WORD_W  = 16;
  localparam int LC3B_LINE_W  = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_cache_size;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D, ARB_DONE} lc3b_arb_state;
  typedef enum logic {ARB_I, ARB_D} lc3b_arb_side;

endpackage

// File: rtl/l2_arb_pick.sv
// Winner select between I-side and D-side line requests; purely combinational.
// L2ARB_RR_EN: alternate on contention against last_grant; otherwise D-side has fixed priority.
module l2_arb_pick
  import l2_port_arbiter_pkg::*;
(
  input  logic         i_req_i,
  input  logic         d_req_i,
  input  lc3b_arb_side last_grant_i,
  output logic         grant_vld_o,
  output lc3b_arb_side grant_o
);

  assign grant_vld_o = i_req_i | d_req_i;

`ifdef L2ARB_RR_EN
  always_comb begin
    grant_o = ARB_I;
    if (i_req_i && d_req_i) begin
      grant_o = (last_grant_i == ARB_I) ? ARB_D : ARB_I;
    end else if (d_req_i) begin
      grant_o = ARB_D;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_grant_i;
  assign grant_o     = d_req_i ? ARB_D : ARB_I;
`endif

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 line port between I-cache reads and D-cache reads/writebacks, one txn in flight.
// Strobes registered one cycle after grant; responses pass through combinationally. Requesters hold until resp.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = LC3B_WORD_W,
  parameter int LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  lc3b_arb_state     state_q, state_d;
  lc3b_arb_side      last_q, last_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic              d_req;
  logic              grant_vld;
  lc3b_arb_side      grant;

  assign d_req = d_read | d_write;

  l2_arb_pick u_pick (
    .i_req_i      (i_read),
    .d_req_i      (d_req),
    .last_grant_i (last_q),
    .grant_vld_o  (grant_vld),
    .grant_o      (grant)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_vld) begin
          if (grant == ARB_D) begin
            // A simultaneous read+write from D is a writeback.
            state_d = ARB_SERVE_D;
            wr_d    = d_write;
            rd_d    = ~d_write;
            addr_d  = d_address;
            wdata_d = d_wdata;
          end else begin
            state_d = ARB_SERVE_I;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
            addr_d  = i_address;
          end
        end
      end
      ARB_SERVE_I: begin
        if (l2_resp) begin
          state_d = ARB_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          last_d  = ARB_I;
        end
      end
      ARB_SERVE_D: begin
        if (l2_resp) begin
          state_d = ARB_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          last_d  = ARB_D;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_I;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign l2_read    = rd_q;
  assign l2_write   = wr_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  // A requester that withdrew before completion does not see the response.
  assign i_resp  = (state_q == ARB_SERVE_I) & l2_resp & i_read;
  assign d_resp  = (state_q == ARB_SERVE_D) & l2_resp & d_req;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

`ifdef L2ARB_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(d_read && d_write)) else $error("d_read and d_write both high");
    end
  end
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed vector table, multi-cycle corner sequences and randomized traffic against a transaction-level model.
module tb_l2_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, d_read, d_write, l2_resp;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata, l2_rdata;
  logic [127:0] i_rdata, d_rdata, l2_wdata;
  logic         i_resp, d_resp, l2_read, l2_write;
  logic [15:0]  l2_address;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic wait_strobe();
    bit ok;
    int c;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < 20) begin
      step();
      ok = l2_read | l2_write;
      c++;
    end
    if (!ok) check("strobe_timeout", 0, 1);
  endtask

  // Called in the first strobe cycle; ends in the DONE bubble cycle.
  task automatic respond(input int lat, input logic [127:0] rdat, input bit withdraw,
                         output bit gi, output bit gd, output logic [127:0] ird,
                         output logic [127:0] drd);
    logic [17:0] snap;
    snap = {l2_read, l2_write, l2_address};
    for (int c = 1; c < lat; c++) begin
      step();
      check("hold_stable", {l2_read, l2_write, l2_address}, snap);
      check("no_early_resp", {i_resp, d_resp}, 0);
    end
    if (withdraw) drop_reqs();
    l2_resp  = 1'b1;
    l2_rdata = rdat;
    #1;
    gi  = i_resp;
    gd  = d_resp;
    ird = i_rdata;
    drd = d_rdata;
    step();
    l2_resp = 1'b0;
    check("strobe_clear", {l2_read, l2_write}, 0);
  endtask

  typedef struct {
    logic         ir, dr, dw;
    logic [15:0]  ia, da;
    logic [127:0] wd, rdat;
    int           lat;
    bit           exp_d;
    logic         exp_rd, exp_wr;
    logic [15:0]  exp_addr;
  } vec_t;

  vec_t vt[6];

  bit           gi, gd, side_d;
  logic [127:0] ird, drd;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1,0,0, 16'h1230,16'h0000, '0, {16{8'hA5}}, 2, 0, 1,0, 16'h1230};
    vt[1] = '{0,0,1, 16'h0000,16'h4440, 128'h0123456789abcdef_fedcba9876543210,
              {16{8'h3C}}, 1, 1, 0,1, 16'h4440};
    vt[2] = '{0,1,0, 16'h0000,16'h0800, '0, {8{16'hBEEF}}, 3, 1, 1,0, 16'h0800};
    vt[3] = '{1,0,0, 16'hFFF0,16'h0000, '0, {4{32'h600DF00D}}, 1, 0, 1,0, 16'hFFF0};
    vt[4] = '{1,1,0, 16'h0010,16'h0020, '0, {16{8'h11}}, 1, 1, 1,0, 16'h0020};
`ifdef L2ARB_RR_EN
    vt[5] = '{1,0,1, 16'h0030,16'h0040, {8{16'h7777}}, {16{8'h22}}, 2, 0, 1,0, 16'h0030};
`else
    vt[5] = '{1,0,1, 16'h0030,16'h0040, {8{16'h7777}}, {16{8'h22}}, 2, 1, 0,1, 16'h0040};
`endif

    rst_n = 1'b0;
    drop_reqs();
    l2_resp = 1'b0; l2_rdata = '0; i_address = '0; d_address = '0; d_wdata = '0;
    step(); step();
    check("rst_strobes", {l2_read, l2_write}, 0);
    check("rst_addr", l2_address, 0);
    check("rst_wdata", l2_wdata, 0);
    check("rst_resp", {i_resp, d_resp}, 0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      i_read = vt[v].ir; d_read = vt[v].dr; d_write = vt[v].dw;
      i_address = vt[v].ia; d_address = vt[v].da; d_wdata = vt[v].wd;
      check("pre_grant_idle", {l2_read, l2_write}, 0);
      wait_strobe();
      check("vec_rd", l2_read, vt[v].exp_rd);
      check("vec_wr", l2_write, vt[v].exp_wr);
      check("vec_addr", l2_address, vt[v].exp_addr);
      if (vt[v].exp_d) check("vec_wdata", l2_wdata, vt[v].wd);
      respond(vt[v].lat, vt[v].rdat, 1'b0, gi, gd, ird, drd);
      check("vec_resp", {gi, gd}, vt[v].exp_d ? 2'b01 : 2'b10);
      check("vec_rdata", vt[v].exp_d ? drd : ird, vt[v].rdat);
      check("vec_resp_one_cycle", {i_resp, d_resp}, 0);
      drop_reqs();
      step();
    end

    // Both sides held continuously across four grants.
    i_read = 1'b1; i_address = 16'h1111;
    d_read = 1'b1; d_address = 16'h2222;
    for (int g = 0; g < 4; g++) begin
`ifdef L2ARB_RR_EN
      side_d = (g % 2 == 0);
`else
      side_d = 1'b1;
`endif
      wait_strobe();
      check("cont_addr", l2_address, side_d ? 16'h2222 : 16'h1111);
      respond(1, {8{16'h5A00 + 16'(g)}}, 1'b0, gi, gd, ird, drd);
      check("cont_grant", {gi, gd}, side_d ? 2'b01 : 2'b10);
    end
    drop_reqs();
    step(); step();

    // Reset while serving a D read aborts it silently.
    d_read = 1'b1; d_address = 16'h5550;
    wait_strobe();
    check("abort_pre_rd", l2_read, 1);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {l2_read, l2_write}, 0);
    check("abort_addr", l2_address, 0);
    check("abort_wdata", l2_wdata, 0);
    d_read = 1'b0;
    l2_resp = 1'b1;
    #1;
    check("abort_resp_in_rst", {i_resp, d_resp}, 0);
    l2_resp = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      l2_resp = 1'b1;
      #1;
      check("abort_no_late_resp", {i_resp, d_resp}, 0);
      step();
      l2_resp = 1'b0;
    end
    step();

    // Stray L2 response while idle, then D read+write collision.
    l2_resp = 1'b1;
    #1;
    check("stray_resp", {i_resp, d_resp}, 0);
    step();
    l2_resp = 1'b0;
    check("stray_state", {l2_read, l2_write}, 0);
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h6660; d_wdata = {4{32'hCAFEF00D}};
    wait_strobe();
    check("dual_wr", {l2_read, l2_write}, 2'b01);
    check("dual_addr", l2_address, 16'h6660);
    check("dual_wdata", l2_wdata, {4{32'hCAFEF00D}});
    respond(2, '0, 1'b0, gi, gd, ird, drd);
    check("dual_resp", {gi, gd}, 2'b01);
    drop_reqs();
    step();

    begin
      bit   m_last_d, win_d, want_i, want_d, wdr;
      logic rr, rdr, rw;
      logic [127:0] rdat, wd;
      logic [15:0] ia, da;
      int lat;
      m_last_d = 1'b1;   // collision above granted D
`ifdef L2ARB_RR_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      for (int t = 0; t < 40; t++) begin
        want_i = 1'($urandom_range(0, 1));
        rdr    = 1'($urandom_range(0, 1));
        rw     = 1'($urandom_range(0, 1));
        want_d = rdr | rw;
        if (!want_i && !want_d) want_i = 1'b1;
        ia   = 16'($urandom);
        da   = 16'($urandom);
        wd   = {$urandom, $urandom, $urandom, $urandom};
        rdat = {$urandom, $urandom, $urandom, $urandom};
        lat  = $urandom_range(1, 3);
        wdr  = ($urandom_range(0, 9) == 0);
        if (want_i && want_d) win_d = rr ? !m_last_d : 1'b1;
        else                  win_d = want_d;
        i_read = want_i; d_read = rdr; d_write = rw;
        i_address = ia; d_address = da; d_wdata = wd;
        wait_strobe();
        check("rnd_rd", l2_read, win_d ? !rw : 1'b1);
        check("rnd_wr", l2_write, win_d ? rw : 1'b0);
        check("rnd_addr", l2_address, win_d ? da : ia);
        if (win_d) check("rnd_wdata", l2_wdata, wd);
        respond(lat, rdat, wdr, gi, gd, ird, drd);
        if (wdr)        check("rnd_dropped", {gi, gd}, 0);
        else if (win_d) check("rnd_resp_d", {gi, gd, drd}, {2'b01, rdat});
        else            check("rnd_resp_i", {gi, gd, ird}, {2'b10, rdat});
        m_last_d = win_d;
        drop_reqs();
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
